// File: rtl/gpio_tx_pkg.sv
// Shared constants and types for the GPIO code transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package gpio_tx_pkg;

   localparam int CODE_W             = 3;
   localparam int DEF_SETUP_CYCLES   = 50;
   localparam int DEF_TIMEOUT_CYCLES = 500000;   // 10 ms at 50 MHz
   localparam int DEF_GAP_CYCLES     = 25;
   localparam int DEF_FIFO_DEPTH     = 4;

   typedef logic [CODE_W-1:0] code_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_GAP    = 3'd4
   } tx_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/code_fifo.sv
// Small show-ahead queue of event codes waiting for transmission.
// Latency: a pushed entry is visible on dout the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
//
// Ports: clk, reset (sync, active-high), push/din write side,
//        pop/dout read side (dout is the head, valid while !empty), full, empty.
// DEPTH must be a power of two, at least 2.
module code_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         push_ok;
   logic         pop_ok;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (push_ok && !reset) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/gpio_code_tx.sv
// Queues 3-bit event codes and hands each to a host over GPIO with a strobe/ack handshake.
// Latency: a code sent into an idle block reaches gpio_data two cycles later; strobe follows SETUP_CYCLES on.
// Backpressure: none upstream; a send into a full queue is dropped and latches overflow.
//
// Ports: CLOCK_50, reset (sync, active-high), send/code enqueue side,
//        ack_in (asynchronous host acknowledge), gpio_data/gpio_strobe host side,
//        busy, done, timeout_err, overflow status flags.
module gpio_code_tx
   import gpio_tx_pkg::*;
#(
   parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              send,
   input  logic [CODE_W-1:0] code,
   input  logic              ack_in,
   output logic [CODE_W-1:0] gpio_data,
   output logic              gpio_strobe,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic              overflow
);

   localparam int CNT_W = $clog2(max3(SETUP_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES) + 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

   tx_state_t        state;
   tx_state_t        state_nxt;
   logic [CNT_W-1:0] cnt;
   code_t            frame;
   code_t            fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   logic             ack_m;
   logic             ack_s;
   logic             done_nxt;
   logic             tmo_nxt;

   // Two-flop synchronizer for the host acknowledge.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         ack_m <= 1'b0;
         ack_s <= 1'b0;
      end else begin
         ack_m <= ack_in;
         ack_s <= ack_m;
      end
   end

   // Popping frees a slot in the same cycle, so a push on a full queue still lands.
   assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
   assign fifo_push = send && (!fifo_full || fifo_pop);

   code_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (CODE_W)
   ) u_fifo (
      .clk   (CLOCK_50),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (code),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Ack is only looked at in STROBE and HOLD; SETUP and GAP run on time alone.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      tmo_nxt   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) state_nxt = ST_SETUP;
         end
         ST_SETUP: begin
            if (cnt == SETUP_LAST) state_nxt = ST_STROBE;
         end
         ST_STROBE: begin
            if (ack_s) begin
               state_nxt = ST_HOLD;
            end else if (cnt == TMO_LAST) begin
               state_nxt = ST_GAP;
               tmo_nxt   = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!ack_s) begin
               state_nxt = ST_GAP;
               done_nxt  = 1'b1;
            end else if (cnt == TMO_LAST) begin
               state_nxt = ST_GAP;
               tmo_nxt   = 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt == GAP_LAST) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         frame       <= '0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state       <= state_nxt;
         done        <= done_nxt;
         timeout_err <= tmo_nxt;
         // Counter restarts on every state change and saturates rather than wrapping.
         if (state_nxt != state)   cnt <= '0;
         else if (cnt != '1)       cnt <= cnt + 1'b1;
         if (fifo_pop)             frame <= fifo_dout;
         if (send && fifo_full && !fifo_pop) overflow <= 1'b1;
      end
   end

   assign gpio_strobe = (state == ST_STROBE);
   assign gpio_data   = ((state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD))
                        ? frame : '0;
   assign busy        = (state != ST_IDLE) || !fifo_empty;

endmodule
